// File: rtl/uart_pkg.sv
// Shared types and timing helpers for the uart transmitter and receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int half_bit(input int cpb);
    return cpb / 2;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart.sv
// Full-duplex UART: independent TX and RX state machines sharing one clock.
//
// state     | meaning
// TX_IDLE   | line high, waiting for tx_start
// TX_START  | driving start bit (low) for one bit time
// TX_DATA   | driving data bits LSB first, one bit time each
// TX_STOP   | driving stop bit(s) high, then release tx_busy
// RX_IDLE   | waiting for synchronised rx to fall
// RX_START  | half a bit in, confirm start bit still low
// RX_DATA   | sampling data bits mid-bit, LSB first
// RX_STOP   | sampling stop bit(s) mid-bit, publish byte if all high
// RX_WAIT   | framing error, waiting for line to return high
module uart
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_busy,
  output logic                 tx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ready,
  input  logic                 rx_ack,
  input  logic                 rx
);

  localparam int CPB     = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF    = half_bit(CPB);
  localparam int HALF_M1 = (HALF > 0) ? HALF - 1 : 0;
  localparam int CW      = $clog2(CPB * STOP_BITS + 1);
  localparam int BW      = $clog2(DATA_BITS + 1);

  tx_state_t            tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_shift;

  rx_state_t            rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_s;

  uart_sync2 #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // Counters count down from the period minus one; a phase ends at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx <= 1'b1;
          if (tx_start) begin
            tx_shift <= tx_data;
            tx_busy  <= 1'b1;
            tx       <= 1'b0;
            tx_cnt   <= CW'(CPB - 1);
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == '0) begin
            tx       <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_bit   <= '0;
            tx_cnt   <= CW'(CPB - 1);
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == '0) begin
            if (tx_bit == BW'(DATA_BITS - 1)) begin
              tx       <= 1'b1;
              tx_cnt   <= CW'(STOP_BITS * CPB - 1);
              tx_state <= TX_STOP;
            end else begin
              tx       <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_bit   <= tx_bit + 1'b1;
              tx_cnt   <= CW'(CPB - 1);
            end
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == '0) begin
            tx_busy  <= 1'b0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // A completing byte is assigned after the ack clear so it takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_ready <= 1'b0;
    end else begin
      if (rx_ack) rx_ready <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s) begin
            rx_cnt   <= CW'(HALF_M1);
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == '0) begin
            if (!rx_s) begin
              rx_bit   <= '0;
              rx_cnt   <= CW'(CPB - 1);
              rx_state <= RX_DATA;
            end else begin
              rx_state <= RX_IDLE;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == '0) begin
            rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
            rx_cnt   <= CW'(CPB - 1);
            if (rx_bit == BW'(DATA_BITS - 1)) begin
              rx_bit   <= '0;
              rx_state <= RX_STOP;
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == '0) begin
            if (!rx_s) begin
              rx_state <= RX_WAIT;
            end else if (rx_bit == BW'(STOP_BITS - 1)) begin
              rx_data  <= rx_shift;
              rx_ready <= 1'b1;
              rx_state <= RX_IDLE;
            end else begin
              rx_bit <= rx_bit + 1'b1;
              rx_cnt <= CW'(CPB - 1);
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        RX_WAIT: begin
          if (rx_s) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart.sv
// Directed bench: instance A transmits into instance B; B's rx can also be driven directly.
module tb_uart;

  localparam int CPB     = 17;   // 1_000_000 / 57_600 truncated
  localparam int FRAME   = 170;  // (1 + 8 + 1) * CPB
  localparam int SPACING = 200;
  localparam int LIMIT   = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a_tx_data = '0;
  logic       a_tx_start = 1'b0;
  logic       a_tx_busy, a_tx;
  logic [7:0] a_rx_data;
  logic       a_rx_ready;
  logic       b_tx_busy, b_tx;
  logic [7:0] b_rx_data;
  logic       b_rx_ready;
  logic       b_rx_ack = 1'b0;
  logic       b_rx;
  logic       tb_rx = 1'b1;
  logic       rx_sel = 1'b0;
  logic       auto_ack = 1'b1;
  logic       prev_ready = 1'b0;

  int total = 0;
  int bad   = 0;
  logic [7:0] rx_q[$];
  logic [7:0] stream[$];
  logic       exp_bits[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  assign b_rx = rx_sel ? tb_rx : a_tx;

  always #5 clk = ~clk;

  uart #(.CLK_FREQ(1000000), .BAUD_RATE(57600), .DATA_BITS(8), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .tx_data(a_tx_data), .tx_start(a_tx_start), .tx_busy(a_tx_busy),
    .tx(a_tx), .rx_data(a_rx_data), .rx_ready(a_rx_ready), .rx_ack(1'b0), .rx(b_tx)
  );

  uart #(.CLK_FREQ(1000000), .BAUD_RATE(57600), .DATA_BITS(8), .STOP_BITS(1)) u_b (
    .clk(clk), .rst(rst), .tx_data(8'h00), .tx_start(1'b0), .tx_busy(b_tx_busy),
    .tx(b_tx), .rx_data(b_rx_data), .rx_ready(b_rx_ready), .rx_ack(b_rx_ack), .rx(b_rx)
  );

  // Receive monitor: records each rising rx_ready, acks one cycle later when enabled.
  initial forever begin
    @(posedge clk);
    #1;
    if (b_rx_ready && !prev_ready) rx_q.push_back(b_rx_data);
    prev_ready = b_rx_ready;
    if (auto_ack) b_rx_ack = b_rx_ready;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    a_tx_data  = d;
    a_tx_start = 1'b1;
    tick(1);
    a_tx_start = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    int t = 0;
    while (rx_q.size() < n && t < LIMIT) begin
      tick(1);
      t++;
    end
    check("rx_wait", 32'(rx_q.size() >= n), 32'd1);
  endtask

  task automatic wait_tx_idle();
    int t = 0;
    while (a_tx_busy && t < LIMIT) begin
      tick(1);
      t++;
    end
    check("tx_idle_wait", 32'(a_tx_busy), 32'd0);
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic stop_val);
    tb_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      tb_rx = d[i];
      tick(CPB);
    end
    tb_rx = stop_val;
    tick(CPB);
    tb_rx = 1'b1;
    tick(CPB);
  endtask

  initial begin
    int cnt;

    // reset values
    tick(3);
    check("rst_tx", 32'(a_tx), 32'd1);
    check("rst_tx_busy", 32'(a_tx_busy), 32'd0);
    check("rst_rx_ready", 32'(b_rx_ready), 32'd0);
    check("rst_rx_data", 32'(b_rx_data), 32'h00);
    rst = 1'b0;
    tick(3);

    // 0xA5 waveform and bit timing
    send_byte(8'hA5);
    check("a5_start_edge", 32'(a_tx), 32'd0);
    check("a5_busy_set", 32'(a_tx_busy), 32'd1);
    tick(CPB - 1);
    check("a5_start_last", 32'(a_tx), 32'd0);
    tick(1);
    check("a5_bit0", 32'(a_tx), 32'(exp_bits[0]));
    for (int i = 1; i < 8; i++) begin
      tick(CPB);
      check($sformatf("a5_bit%0d", i), 32'(a_tx), 32'(exp_bits[i]));
    end
    tick(CPB);
    check("a5_stop", 32'(a_tx), 32'd1);
    check("a5_stop_busy", 32'(a_tx_busy), 32'd1);
    tick(CPB - 1);
    check("a5_busy_last", 32'(a_tx_busy), 32'd1);
    tick(1);
    check("a5_busy_clear", 32'(a_tx_busy), 32'd0);
    wait_rx(1);
    check("a5_rx", 32'(rx_q[0]), 32'hA5);
    tick(3);
    check("a5_acked", 32'(b_rx_ready), 32'd0);
    check("a5_rx_data_held", 32'(b_rx_data), 32'hA5);

    // 28-byte stream
    stream = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'hFF, 8'hAA, 8'h55, 8'hC3, 8'h3C, 8'hF0, 8'h0F};
    for (int i = 0; i < 16; i++) stream.push_back(8'(i));
    rx_q.delete();
    foreach (stream[i]) begin
      send_byte(stream[i]);
      tick(SPACING - 1);
    end
    check("stream_count", 32'(rx_q.size()), 32'd28);
    foreach (stream[i]) begin
      if (i < rx_q.size()) check($sformatf("stream_%0d", i), 32'(rx_q[i]), 32'(stream[i]));
    end

    // tx_start while busy is ignored; busy lasts exactly one frame
    rx_q.delete();
    send_byte(8'h12);
    cnt = 0;
    while (a_tx_busy && cnt < LIMIT) begin
      if (cnt == 5) begin
        a_tx_data  = 8'h99;
        a_tx_start = 1'b1;
      end else begin
        a_tx_start = 1'b0;
      end
      tick(1);
      cnt++;
    end
    a_tx_start = 1'b0;
    check("busy_length", 32'(cnt), 32'd170);
    tick(SPACING);
    check("busy_ignore_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check("busy_ignore_data", 32'(rx_q[0]), 32'h12);

    // false start rejected
    rx_sel = 1'b1;
    rx_q.delete();
    tb_rx = 1'b0;
    tick(4);
    tb_rx = 1'b1;
    tick(3 * CPB);
    check("false_start_q", 32'(rx_q.size()), 32'd0);
    check("false_start_ready", 32'(b_rx_ready), 32'd0);

    // framing error drops byte; next valid frame received
    drive_frame(8'h3C, 1'b0);
    tick(CPB);
    check("frame_err_q", 32'(rx_q.size()), 32'd0);
    check("frame_err_ready", 32'(b_rx_ready), 32'd0);
    drive_frame(8'h5A, 1'b1);
    wait_rx(1);
    if (rx_q.size() > 0) check("after_err_data", 32'(rx_q[0]), 32'h5A);

    // overrun: data overwritten, ready held
    auto_ack = 1'b0;
    b_rx_ack = 1'b0;
    tick(2);
    rx_q.delete();
    drive_frame(8'h11, 1'b1);
    check("ovr_first_ready", 32'(b_rx_ready), 32'd1);
    check("ovr_first_data", 32'(b_rx_data), 32'h11);
    drive_frame(8'h22, 1'b1);
    check("ovr_second_ready", 32'(b_rx_ready), 32'd1);
    check("ovr_second_data", 32'(b_rx_data), 32'h22);
    b_rx_ack = 1'b1;
    tick(1);
    check("ack_clears", 32'(b_rx_ready), 32'd0);

    // ack held through completion: completion wins for one cycle
    rx_q.delete();
    drive_frame(8'h44, 1'b1);
    check("ack_hold_seen", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check("ack_hold_data", 32'(rx_q[0]), 32'h44);
    check("ack_hold_cleared", 32'(b_rx_ready), 32'd0);
    b_rx_ack = 1'b0;
    rx_sel = 1'b0;
    tick(2);

    // reset mid-frame
    rx_q.delete();
    send_byte(8'h66);
    wait_rx(1);
    check("pre_rst_ready", 32'(b_rx_ready), 32'd1);
    wait_tx_idle();
    send_byte(8'hF7);
    tick(3 * CPB);
    rst = 1'b1;
    #1;
    check("mid_rst_tx", 32'(a_tx), 32'd1);
    check("mid_rst_busy", 32'(a_tx_busy), 32'd0);
    check("mid_rst_ready", 32'(b_rx_ready), 32'd0);
    tick(2);
    rst = 1'b0;
    auto_ack = 1'b1;
    tick(2);
    rx_q.delete();
    send_byte(8'h81);
    tick(SPACING);
    check("post_rst_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) check("post_rst_data", 32'(rx_q[0]), 32'h81);

    // reverse direction stays quiet
    check("a_rx_ready_idle", 32'(a_rx_ready), 32'd0);
    check("a_rx_data_idle", 32'(a_rx_data), 32'h00);
    check("b_tx_busy_idle", 32'(b_tx_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
